// File: rtl/telem_pcm_formatter.sv
// Assembles Z7-sampled discrete nibbles into words, buffers them, and serializes sync-prefixed PCM frames.
// Optional feature macro: TELEM_PARITY_EN appends one odd-parity bit after each data word.
module telem_pcm_formatter #(
  parameter int         NIBBLES    = 6,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC       = 8'hE2
) (
  input  logic                              SIM_CLK,
  input  logic                              SIM_RST,
  input  logic                              Z7,
  input  logic                              DLS,
  input  logic                              DC3R,
  input  logic                              DC4R,
  input  logic                              DDC1R,
  input  logic                              DDC2R,
  input  logic                              PCM_RDY,
  output logic                              PCM_VLD,
  output logic                              PCM_BIT,
  output logic                              PCM_FRM,
  output logic                              OVF,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   WCNT
);

  localparam int WW = 4 * NIBBLES;
  localparam int FW = 8 + WW;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int BW = $clog2((WW > 8) ? WW : 8);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_PAR} state_t;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

`ifdef TELEM_PARITY_EN
  function automatic logic odd_parity(input logic [WW-1:0] w);
    return ~^w;
  endfunction
`endif

  // Stage p0: nibble assembler
  logic [3:0]    nib;
  logic [WW-1:0] word_p0, word_nx;
  logic [NW-1:0] ncnt_p0;
  logic          dls_p0, cap, push;

  assign nib     = {DDC1R, DDC2R, DC3R, DC4R};
  assign cap     = Z7 & DLS;
  assign word_nx = {word_p0[WW-5:0], nib};
  assign push    = cap && (ncnt_p0 == NW'(NIBBLES - 1));

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      ncnt_p0 <= '0;
      dls_p0  <= 1'b0;
    end else begin
      dls_p0 <= DLS;
      if (cap)
        ncnt_p0 <= push ? '0 : ncnt_p0 + NW'(1);
      else if (dls_p0 && !DLS && ncnt_p0 != '0)
        ncnt_p0 <= '0;
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (cap) word_p0 <= word_nx;
  end

  // Word FIFO between assembler and serializer
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] fcnt;
  logic          full, empty, push_ok, pop, ovf_q;

  assign full    = (fcnt == CW'(FIFO_DEPTH));
  assign empty   = (fcnt == '0);
  assign push_ok = push & ~full;
  assign OVF     = ovf_q;
  assign WCNT    = fcnt;

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      wptr  <= '0;
      rptr  <= '0;
      fcnt  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_ok) wptr <= ptr_inc(wptr);
      if (pop)     rptr <= ptr_inc(rptr);
      case ({push_ok, pop})
        2'b10:   fcnt <= fcnt + CW'(1);
        2'b01:   fcnt <= fcnt - CW'(1);
        default: fcnt <= fcnt;
      endcase
      if (push && full) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (push_ok) mem[wptr] <= word_nx;
  end

  // Stage p1: frame serializer
  state_t        state_p1, state_nx;
  logic [BW-1:0] bcnt_p1, bcnt_nx;
  logic [FW-1:0] frame_p1;
  logic          xfer, frame_done;
`ifdef TELEM_PARITY_EN
  logic          par_p1;
`endif

  assign PCM_VLD = (state_p1 != S_IDLE);
  assign xfer    = PCM_VLD & PCM_RDY;
  assign PCM_FRM = (state_p1 == S_SYNC) && (bcnt_p1 == '0);

  always_comb begin
    state_nx   = state_p1;
    bcnt_nx    = bcnt_p1;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state_p1)
      S_IDLE: if (!empty) begin
        pop      = 1'b1;
        state_nx = S_SYNC;
        bcnt_nx  = '0;
      end
      S_SYNC: if (xfer) begin
        if (bcnt_p1 == BW'(7)) begin
          state_nx = S_DATA;
          bcnt_nx  = '0;
        end else begin
          bcnt_nx = bcnt_p1 + BW'(1);
        end
      end
      S_DATA: if (xfer) begin
        if (bcnt_p1 == BW'(WW - 1)) begin
`ifdef TELEM_PARITY_EN
          state_nx = S_PAR;
          bcnt_nx  = '0;
`else
          frame_done = 1'b1;
`endif
        end else begin
          bcnt_nx = bcnt_p1 + BW'(1);
        end
      end
      S_PAR: if (xfer) frame_done = 1'b1;
      default: state_nx = S_IDLE;
    endcase
    // Chain straight into the next frame when a word is already waiting
    if (frame_done) begin
      bcnt_nx = '0;
      if (!empty) begin
        pop      = 1'b1;
        state_nx = S_SYNC;
      end else begin
        state_nx = S_IDLE;
      end
    end
  end

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state_p1 <= S_IDLE;
      bcnt_p1  <= '0;
    end else begin
      state_p1 <= state_nx;
      bcnt_p1  <= bcnt_nx;
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (pop) begin
      frame_p1 <= {SYNC, mem[rptr]};
`ifdef TELEM_PARITY_EN
      par_p1   <= odd_parity(mem[rptr]);
`endif
    end else if (xfer) begin
      frame_p1 <= {frame_p1[FW-2:0], 1'b0};
    end
  end

  always_comb begin
    PCM_BIT = 1'b0;
    if (state_p1 == S_SYNC || state_p1 == S_DATA) PCM_BIT = frame_p1[FW-1];
`ifdef TELEM_PARITY_EN
    if (state_p1 == S_PAR) PCM_BIT = par_p1;
`endif
  end

endmodule
